// File: rtl/ibuf_scoreboard_pkg.sv
// Shared constants and types for the issue-slice scoreboard.
// The width constants track the default slice configuration.
package ibuf_scoreboard_pkg;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_WIS_DEF  = 4;
  localparam int NUM_REGS_DEF = 64;
  localparam int NR_BITS      = $clog2(NUM_REGS_DEF);
  localparam int ISSUE_WIS_W  = log2up(NUM_WIS_DEF);

  typedef struct packed {
    logic               wb;
    logic [NR_BITS-1:0] rd;
    logic [NR_BITS-1:0] rs1;
    logic [NR_BITS-1:0] rs2;
    logic [NR_BITS-1:0] rs3;
  } reg_sel_t;

endpackage

// File: rtl/ibuf_scoreboard_out_reg.sv
// One-entry valid/ready pipeline register with asynchronous reset.
// It accepts a new entry whenever it is empty or being drained in the same cycle.
module sb_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ibuf_scoreboard.sv
// Issue-slice scoreboard: holds back head instructions with pending operands or
// destination, and forwards hazard-free ones through a registered output stage.
module ibuf_scoreboard
  import ibuf_scoreboard_pkg::*;
#(
  parameter int NUM_WIS  = 4,
  parameter int NUM_REGS = 64,
  parameter int DATAW    = 128,
  localparam int RB      = $clog2(NUM_REGS),
  localparam int WW      = log2up(NUM_WIS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  input  logic [WW-1:0]    in_wis,
  input  logic             in_wb,
  input  logic [RB-1:0]    in_rd,
  input  logic [RB-1:0]    in_rs1,
  input  logic [RB-1:0]    in_rs2,
  input  logic [RB-1:0]    in_rs3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [WW-1:0]    out_wis,
  input  logic             wb_valid,
  input  logic [WW-1:0]    wb_wis,
  input  logic [RB-1:0]    wb_rd,
  input  logic             wb_eop,
  output logic [31:0]      perf_stalls
);

  logic [NUM_WIS-1:0][NUM_REGS-1:0] busy;
  logic [NUM_WIS-1:0][NUM_REGS-1:0] busy_next;
  logic [NUM_WIS-1:0][NUM_REGS-1:0] release_mask;
  logic [NUM_REGS-1:0]              eff_row;
  logic [WW+DATAW-1:0]              out_bundle;
  reg_sel_t                         sel;
  logic                             hazard;
  logic                             stage_ready;
  logic                             fire_in;

  assign sel = '{wb: in_wb, rd: in_rd, rs1: in_rs1, rs2: in_rs2, rs3: in_rs3};

  // Only the end-of-packet writeback frees a register; partial writebacks are ignored.
  always_comb begin
    release_mask = '0;
    if (wb_valid && wb_eop) begin
      release_mask[wb_wis][wb_rd] = 1'b1;
    end
  end

  // Releasing writebacks are bypassed so a waiting instruction can go the same cycle.
  assign eff_row = busy[in_wis] & ~release_mask[in_wis];
  assign hazard  = eff_row[sel.rs1] | eff_row[sel.rs2] | eff_row[sel.rs3] |
                   (sel.wb & eff_row[sel.rd]);

  assign in_ready = !hazard && stage_ready;
  assign fire_in  = in_valid && in_ready;

  // The set is applied after the release so a new claim wins over a same-cycle free.
  always_comb begin
    busy_next = busy & ~release_mask;
    if (fire_in && sel.wb && (sel.rd != '0)) begin
      busy_next[in_wis][sel.rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls <= '0;
    end else if (in_valid && hazard) begin
      perf_stalls <= perf_stalls + 32'd1;
    end
  end

  sb_out_reg #(
    .WIDTH(WW + DATAW)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid && !hazard),
    .in_ready (stage_ready),
    .in_data  ({in_wis, in_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_bundle)
  );

  assign {out_wis, out_data} = out_bundle;

endmodule

// File: doc/ibuf_scoreboard.md
# ibuf_scoreboard

- Issue-slice scoreboard, placed directly downstream of one instruction-buffer slice.
- Tracks in-flight destination registers per warp and holds back any head instruction whose operands or destination are still pending.
- Forwards hazard-free instructions through a one-entry registered output stage toward operand collection.
- Clears pending state on writeback; a multi-register operation (e.g. a split MMUL sequence) releases only on its end-of-packet writeback.

## Interface
- `NUM_WIS`, default 4: warps per issue slice.
- `NUM_REGS`, default 64: architectural registers per warp. `NR_BITS` = log2(`NUM_REGS`).
- `DATAW`, default 128: opaque instruction payload width.
- `clk`, input, 1: sole clock.
- `reset`, input, 1: asynchronous, active-high.
- `in_valid`, input, 1: head instruction valid.
- `in_ready`, output, 1: head accepted this cycle.
- `in_data`, input, `DATAW`: payload, passed through unchanged.
- `in_wis`, input, log2up(`NUM_WIS`): warp index within slice.
- `in_wb`, input, 1: instruction writes `in_rd`.
- `in_rd`, `in_rs1`, `in_rs2`, `in_rs3`, input, `NR_BITS` each: destination and source registers.
- `out_valid`, output, 1: issued instruction valid.
- `out_ready`, input, 1: consumer accepts.
- `out_data`, output, `DATAW`: registered payload.
- `out_wis`, output, log2up(`NUM_WIS`): registered warp index.
- `wb_valid`, input, 1: writeback event.
- `wb_wis`, input, log2up(`NUM_WIS`): writeback warp.
- `wb_rd`, input, `NR_BITS`: writeback register.
- `wb_eop`, input, 1: last writeback of the instruction; release only when set.
- `perf_stalls`, output, 32: hazard stall cycle count.

## Operation
- State: `busy[NUM_WIS][NUM_REGS]` bit array; bit `[w][0]` is never set (x0).
- `release[w][r]` = `wb_valid && wb_eop && wb_wis==w && wb_rd==r`.
- Effective busy: `busy & ~release`. Same-cycle writeback release is bypassed into the hazard check.
- Hazard: any effective-busy bit among `rs1`, `rs2`, `rs3`, and `rd` when `in_wb`, all for `in_wis`.
- `fire_in` = `in_valid && !hazard && (!out_valid || out_ready)`; `in_ready` = `fire_in`'s non-valid terms, i.e. `!hazard && (!out_valid || out_ready)`.
- On `fire_in` with `in_wb && in_rd!=0`: set `busy[in_wis][in_rd]`.
- Set and release of the same bit in the same cycle: set wins.
- Output stage:
  - On `fire_in`, load `out_data` and `out_wis`; set `out_valid`.
  - Else if `out_ready`, clear `out_valid`.
- `perf_stalls` increments when `in_valid && hazard`; wraps modulo 2^32.
- `wb_eop=0` writebacks change nothing.
- Release of a non-busy bit is a no-op.

## Timing
- Reset values: `busy` = 0, `out_valid` = 0, `out_data` = 0, `out_wis` = 0, `perf_stalls` = 0. Combinational `in_ready` is then 1 whenever no hazard exists.
- Latency: accepted at edge N, `out_valid` = 1 after edge N.
- Full throughput: one instruction per cycle with `out_ready` held high.
- Back-to-back dependent instructions (RAW on prior `rd`): second stalls until the writeback cycle. It may fire in the same cycle `wb_eop` arrives.
- Output holds `out_data` and `out_valid` stable while `out_ready` = 0.
- Reset asserted mid-operation:
  - Clears all busy bits and the output stage immediately (asynchronous).
  - In-flight writebacks after reset are no-ops.

## Structure
- Shared package holds:
  - `NR_BITS`
  - `ISSUE_WIS_W`
  - a typedef for the register-select bundle (`rd`, `rs1`, `rs2`, `rs3`, `wb`)
- One natural sub-module: `sb_out_reg`, a one-entry valid/ready pipeline register with asynchronous reset, carrying `{out_wis, out_data}`.

## Test plan
- Reset, then instr `wis=0 rd=5 rs1=1 wb=1` -> `out_valid` next cycle, `busy[0][5]`=1, `perf_stalls`=0.
- Then instr `wis=0 rs1=5` -> `in_ready`=0 and `perf_stalls` increments each cycle. Assert `wb_valid wb_wis=0 wb_rd=5 wb_eop=1` -> fires in that same cycle.
- Same `rd=5` pending on `wis=0`; instr `wis=1 rs1=5` -> no stall (per-warp isolation).
- Two `wb_eop=0` writebacks to r5 -> stall persists; the `wb_eop=1` writeback -> released.
- Instr `rd=0 wb=1` twice back-to-back -> no stall, `busy[w][0]` stays 0.
- `out_ready`=0 for 3 cycles with `in_valid` high:
  - `out_data` stable and exactly 1 instruction accepted.
  - Async reset pulse mid-stall -> `out_valid`=0 and all busy bits 0 at once.
